// File: rtl/pci_bus_arbiter_if.sv
// PCI arbiter bus bundle: initiator requests, FRAME#/IRDY# observation and arbiter grant outputs.
interface pci_bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] req_n;
    logic             frame_n;
    logic             irdy_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  owner;
    logic             bus_busy;
    logic             gnt_timeout;

    modport master (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, gnt_timeout
    );

    modport slave (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, gnt_timeout
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter with bus-idle re-arbitration and unused-grant revocation.
module pci_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pci_bus_arbiter_if.master    bus
);
    localparam int CNT_W = $clog2(GNT_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_r, gnt_nxt;
    logic [ID_W-1:0]  owner_r, owner_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_r, busy_nxt;
    logic             tmo_r, tmo_nxt;

    logic             bus_idle;
    logic             any_req;
    logic [ID_W-1:0]  sel;
    logic [N_REQ-1:0] own_mask;
    logic             other_req;

    assign bus_idle = bus.frame_n & bus.irdy_n;

    // Round-robin scan starting one past the last granted index.
    always_comb begin
        any_req = 1'b0;
        sel     = rr_ptr;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!any_req && !bus.req_n[ID_W'((32'(rr_ptr) + i) % N_REQ)]) begin
                any_req = 1'b1;
                sel     = ID_W'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        own_mask        = '0;
        own_mask[owner_r] = 1'b1;
        other_req       = |(~bus.req_n & ~own_mask);
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_r;
        owner_nxt = owner_r;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt;
        busy_nxt  = busy_r;
        tmo_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                gnt_nxt  = '1;
                busy_nxt = 1'b0;
                if (any_req && bus_idle) begin
                    gnt_nxt[sel] = 1'b0;
                    owner_nxt    = sel;
                    rr_nxt       = sel;
                    cnt_nxt      = '0;
                    state_nxt    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!bus.frame_n) begin
                    busy_nxt  = 1'b1;
                    state_nxt = S_BUSY;
                end else if (bus.req_n[owner_r]) begin
                    gnt_nxt   = '1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(GNT_TIMEOUT - 1)) begin
                    gnt_nxt   = '1;
                    tmo_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BUSY: begin
                // Once dropped, the grant stays off until the next idle arbitration.
                if (bus.req_n[owner_r] || other_req)
                    gnt_nxt = '1;
                if (bus_idle) begin
                    gnt_nxt   = '1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt_r   <= '1;
            owner_r <= '0;
            rr_ptr  <= ID_W'(N_REQ - 1);
            cnt     <= '0;
            busy_r  <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_r   <= gnt_nxt;
            owner_r <= owner_nxt;
            rr_ptr  <= rr_nxt;
            cnt     <= cnt_nxt;
            busy_r  <= busy_nxt;
            tmo_r   <= tmo_nxt;
        end
    end

    assign bus.gnt_n       = gnt_r;
    assign bus.owner       = owner_r;
    assign bus.bus_busy    = busy_r;
    assign bus.gnt_timeout = tmo_r;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter: a per-edge reference model queues expected outputs, a negedge monitor compares.
module tb_pci_bus_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int GT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pci_bus_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

    pci_bus_arbiter #(.N_REQ(N), .ID_W(IW), .GNT_TIMEOUT(GT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0]  gnt_n;
        logic [IW-1:0] owner;
        logic          busy;
        logic          tmo;
    } resp_t;

    resp_t expq[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference model: holder = initiator holding a grant (-1 none), txn = transaction on the bus.
    int holder  = -1;
    int last    = N - 1;
    int unused  = 0;
    int m_owner = 0;
    bit txn     = 1'b0;

    function automatic bit others_req(int h, logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (i != h && !r[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        resp_t e;
        bit    pulse;
        bit    idle;
        pulse = 1'b0;
        idle  = bus.frame_n && bus.irdy_n;
        if (rst) begin
            holder = -1; txn = 1'b0; unused = 0; last = N - 1; m_owner = 0;
        end else if (txn) begin
            if (idle) begin
                txn = 1'b0; holder = -1;
            end else if (holder >= 0 && (bus.req_n[holder] || others_req(holder, bus.req_n))) begin
                holder = -1;
            end
        end else if (holder >= 0) begin
            if (!bus.frame_n)             txn = 1'b1;
            else if (bus.req_n[holder])   holder = -1;
            else if (unused == GT - 1)    begin holder = -1; pulse = 1'b1; end
            else                          unused++;
        end else if (idle) begin
            for (int k = 1; k <= N; k++) begin
                if (holder < 0 && !bus.req_n[(last + k) % N]) begin
                    holder  = (last + k) % N;
                    last    = holder;
                    m_owner = holder;
                    unused  = 0;
                end
            end
        end
        e.gnt_n = '1;
        if (holder >= 0) e.gnt_n[holder] = 1'b0;
        e.owner = IW'(m_owner);
        e.busy  = txn;
        e.tmo   = pulse;
        expq.push_back(e);
    end

    always @(negedge clk) begin : monitor
        resp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("gnt_n",       32'(bus.gnt_n),       32'(e.gnt_n));
            chk("owner",       32'(bus.owner),       32'(e.owner));
            chk("bus_busy",    32'(bus.bus_busy),    32'(e.busy));
            chk("gnt_timeout", 32'(bus.gnt_timeout), 32'(e.tmo));
            chk("one_grant",   32'($countones(~bus.gnt_n) <= 1), 32'd1);
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.gnt_n != '1) ok = 1'b1;
            else step(1);
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: no grant within 40 cycles, gnt_n=%b", name, bus.gnt_n);
        end
    endtask

    task automatic run_txn(int n);
        bus.frame_n = 1'b0; bus.irdy_n = 1'b0;
        step(n);
        bus.frame_n = 1'b1;
        step(1);
        bus.irdy_n = 1'b1;
    endtask

    task automatic settle();
        bus.req_n = '1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        step(4);
    endtask

    initial begin
        int n16;
        bit seen;
        rst = 1'b1;
        bus.req_n = '1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        step(2);
        rst = 1'b0;

        // Basic grant, transaction, release
        bus.req_n = 4'b1110;
        step(1);
        chk("t1_first_grant", 32'(bus.gnt_n), 32'(4'b1110));
        run_txn(3);
        bus.req_n = 4'b1111;
        step(2);
        settle();

        // Everyone requesting: round-robin with 2-cycle transactions
        bus.req_n = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            wait_grant("t2_grant");
            run_txn(2);
        end
        settle();

        // Unused grant to initiator 1 times out after 16 cycles
        bus.req_n = 4'b1101;
        wait_grant("t3_grant");
        n16 = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.gnt_n == 4'b1101) n16++;
            if (bus.gnt_timeout) seen = 1'b1;
            else step(1);
        end
        chk("t3_timeout_seen", 32'(seen), 32'd1);
        chk("t3_grant_cycles", 32'(n16), 32'd16);
        bus.req_n = 4'b1001;
        wait_grant("t3_next");
        chk("t3_next_is_2", 32'(bus.gnt_n), 32'(4'b1011));
        settle();

        // Request withdrawn during S_GRANT
        bus.req_n = 4'b1110;
        wait_grant("t4_grant");
        step(2);
        bus.req_n = 4'b1111;
        step(1);
        chk("t4_withdraw_gnt", 32'(bus.gnt_n), 32'(4'b1111));
        chk("t4_no_timeout",   32'(bus.gnt_timeout), 32'd0);
        settle();

        // Early grant removal when another initiator requests during a transaction
        bus.req_n = 4'b1101;
        wait_grant("t5_grant");
        bus.frame_n = 1'b0; bus.irdy_n = 1'b0;
        step(1);
        bus.req_n = 4'b0101;
        step(1);
        chk("t5_early_removal", 32'(bus.gnt_n), 32'(4'b1111));
        chk("t5_still_busy",    32'(bus.bus_busy), 32'd1);
        bus.req_n = 4'b0111;
        step(2);
        bus.frame_n = 1'b1;
        step(1);
        bus.irdy_n = 1'b1;
        wait_grant("t5_next");
        chk("t5_next_is_3", 32'(bus.gnt_n), 32'(4'b0111));
        settle();

        // Reset during a transaction
        bus.req_n = 4'b1110;
        wait_grant("t6_grant");
        bus.frame_n = 1'b0; bus.irdy_n = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_state", 32'({bus.gnt_n, bus.bus_busy, bus.owner}), 32'({4'b1111, 1'b0, 2'd0}));
        rst = 1'b0;
        step(2);
        chk("t6_no_grant_while_busy", 32'(bus.gnt_n), 32'(4'b1111));
        bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        step(2);
        settle();

        // Randomised traffic, including foreign bus activity and occasional resets
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) bus.req_n = N'($urandom);
            if (bus.gnt_n != '1 && $urandom_range(0, 1) == 1) begin
                rst = 1'b0;
                run_txn(int'($urandom_range(1, 3)));
            end else begin
                rst         = ($urandom_range(0, 99) == 0);
                bus.frame_n = ($urandom_range(0, 5) != 0);
                bus.irdy_n  = ($urandom_range(0, 5) != 0);
                step(1);
            end
        end
        rst = 1'b0;
        settle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
